// File: rtl/door_lock_controller.sv
`default_nettype none
// ============================================================================
// Module   : door_lock_controller
// Purpose  : Sequential door-lock stage behind the employee access comparator.
//            Releases the strike for a timed window on a valid code, counts
//            consecutive failed entries and enforces a timed lockout with a
//            one-cycle intruder alert, and forces the door open while the
//            emergency exit request is asserted.
// Ports    : clk            - system clock, rising edge
//            rst            - asynchronous, active-high reset
//            code_valid     - one-cycle strobe, code presented this cycle
//            code_match     - comparator result, qualified by code_valid
//            emergency      - level-sensitive fire/earthquake exit request
//            unlock         - door strike release (registered)
//            lockout        - keypad refusal indicator (registered)
//            intruder_alert - one-cycle pulse on lockout entry (registered)
//            fail_count     - current consecutive-failure count
//            state          - 00 LOCKED, 01 UNLOCKED, 10 LOCKOUT, 11 EMERGENCY
// Revision : 1.0 - initial release
// ============================================================================
module door_lock_controller #(
  parameter int unsigned UNLOCK_CYCLES  = 8,   // 1..65535
  parameter int unsigned MAX_FAILS      = 3,   // 1..7
  parameter int unsigned LOCKOUT_CYCLES = 16   // 1..65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       code_valid,
  input  logic       code_match,
  input  logic       emergency,
  output logic       unlock,
  output logic       lockout,
  output logic       intruder_alert,
  output logic [2:0] fail_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_LOCKED    = 2'b00,
    ST_UNLOCKED  = 2'b01,
    ST_LOCKOUT   = 2'b10,
    ST_EMERGENCY = 2'b11
  } state_t;

  // Timers are loaded with N-1 and run down to 0 inclusive, giving N cycles.
  localparam logic [15:0] C_UNLOCK_RELOAD  = 16'(UNLOCK_CYCLES - 1);
  localparam logic [15:0] C_LOCKOUT_RELOAD = 16'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]  C_MAX_FAILS      = 4'(MAX_FAILS);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_timer;
  logic [15:0] w_timer_next;
  logic [2:0]  r_fail_count;
  logic [2:0]  w_fail_next;
  logic        r_alert;
  logic        w_alert_next;
  logic        r_unlock;
  logic        r_lockout;
  logic        w_unlock_next;
  logic        w_lockout_next;
  logic [3:0]  w_fail_inc;

  // One bit wider than the counter so the comparison cannot wrap at 7.
  assign w_fail_inc = {1'b0, r_fail_count} + 4'd1;

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_fail_next  = r_fail_count;
    w_alert_next = 1'b0;

    if (emergency) begin
      // Emergency overrides everything, including any pending expiry.
      w_state_next = ST_EMERGENCY;
      w_fail_next  = 3'd0;
      w_timer_next = 16'd0;
    end else begin
      case (r_state)
        ST_LOCKED: begin
          if (code_valid) begin
            if (code_match) begin
              w_state_next = ST_UNLOCKED;
              w_timer_next = C_UNLOCK_RELOAD;
              w_fail_next  = 3'd0;
            end else if (w_fail_inc < C_MAX_FAILS) begin
              w_fail_next = w_fail_inc[2:0];
            end else begin
              w_state_next = ST_LOCKOUT;
              w_timer_next = C_LOCKOUT_RELOAD;
              w_fail_next  = 3'd0;
              w_alert_next = 1'b1;
            end
          end
        end
        ST_UNLOCKED: begin
          // A fresh valid code restarts the window, even on the final cycle.
          // Mismatches here are ignored and never counted.
          if (code_valid && code_match) begin
            w_timer_next = C_UNLOCK_RELOAD;
          end else if (r_timer == 16'd0) begin
            w_state_next = ST_LOCKED;
          end else begin
            w_timer_next = r_timer - 16'd1;
          end
        end
        ST_LOCKOUT: begin
          if (r_timer == 16'd0) begin
            w_state_next = ST_LOCKED;
          end else begin
            w_timer_next = r_timer - 16'd1;
          end
        end
        ST_EMERGENCY: begin
          w_state_next = ST_LOCKED;
          w_fail_next  = 3'd0;
        end
        default: begin
          w_state_next = ST_LOCKED;
        end
      endcase
    end
  end

  // Outputs are registered copies of the next-state decode, so they follow
  // the registered state exactly (Moore) with no combinational path to ports.
  assign w_unlock_next  = (w_state_next == ST_UNLOCKED) ||
                          (w_state_next == ST_EMERGENCY);
  assign w_lockout_next = (w_state_next == ST_LOCKOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_LOCKED;
      r_timer      <= 16'd0;
      r_fail_count <= 3'd0;
      r_alert      <= 1'b0;
      r_unlock     <= 1'b0;
      r_lockout    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_timer      <= w_timer_next;
      r_fail_count <= w_fail_next;
      r_alert      <= w_alert_next;
      r_unlock     <= w_unlock_next;
      r_lockout    <= w_lockout_next;
    end
  end

  assign unlock         = r_unlock;
  assign lockout        = r_lockout;
  assign intruder_alert = r_alert;
  assign fail_count     = r_fail_count;
  assign state          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_door_lock_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_door_lock_controller
// Purpose  : Self-checking bench for door_lock_controller. Directed scenarios
//            followed by a randomized run against a behavioural model that
//            tracks "cycles of window remaining" rather than a timer register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_door_lock_controller;

  localparam int U = 8;
  localparam int F = 3;
  localparam int L = 16;

  logic       clk;
  logic       rst;
  logic       code_valid;
  logic       code_match;
  logic       emergency;
  logic       unlock;
  logic       lockout;
  logic       intruder_alert;
  logic [2:0] fail_count;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode uses the externally visible state codes.
  int m_mode;
  int m_remain;
  int m_fails;
  bit m_alert;

  door_lock_controller #(
    .UNLOCK_CYCLES (U),
    .MAX_FAILS     (F),
    .LOCKOUT_CYCLES(L)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .code_valid    (code_valid),
    .code_match    (code_match),
    .emergency     (emergency),
    .unlock        (unlock),
    .lockout       (lockout),
    .intruder_alert(intruder_alert),
    .fail_count    (fail_count),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode   = 0;
    m_remain = 0;
    m_fails  = 0;
    m_alert  = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit m, input bit e);
    m_alert = 1'b0;
    if (e) begin
      m_mode   = 3;
      m_fails  = 0;
      m_remain = 0;
    end else begin
      case (m_mode)
        0: if (v) begin
          if (m) begin
            m_mode = 1; m_remain = U; m_fails = 0;
          end else if (m_fails + 1 < F) begin
            m_fails = m_fails + 1;
          end else begin
            m_mode = 2; m_remain = L; m_fails = 0; m_alert = 1'b1;
          end
        end
        1: begin
          if (v && m) m_remain = U;
          else begin
            m_remain = m_remain - 1;
            if (m_remain == 0) m_mode = 0;
          end
        end
        2: begin
          m_remain = m_remain - 1;
          if (m_remain == 0) m_mode = 0;
        end
        default: begin
          m_mode = 0; m_fails = 0;
        end
      endcase
    end
  endtask

  // Drive one cycle, advance the model, and leave time at posedge+1.
  task automatic step(input bit v, input bit m, input bit e);
    code_valid = v;
    code_match = m;
    emergency  = e;
    @(posedge clk);
    model_step(v, m, e);
    #1;
    code_valid = 1'b0;
    code_match = 1'b0;
    emergency  = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({unlock, lockout, intruder_alert, fail_count, state} !== 8'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got u=%b lo=%b a=%b f=%0d s=%0d, want all 0",
               unlock, lockout, intruder_alert, fail_count, state);
    end
  endtask

  task automatic test_unlock();
    do_reset();
    step(1, 1, 0);
    for (int i = 0; i < U; i++) begin
      n_cmp++;
      if (unlock !== 1'b1 || state !== 2'b01) begin
        n_err++;
        $display("FAIL unlock_window[%0d]: got u=%b s=%0d, want u=1 s=1", i, unlock, state);
      end
      step(0, $urandom_range(0, 1), 0);
    end
    n_cmp++;
    if (unlock !== 1'b0 || state !== 2'b00) begin
      n_err++;
      $display("FAIL unlock_expire: got u=%b s=%0d, want u=0 s=0", unlock, state);
    end
  endtask

  task automatic test_lockout();
    do_reset();
    step(1, 0, 0);
    n_cmp++;
    if (fail_count !== 3'd1) begin
      n_err++; $display("FAIL fail1: got %0d want 1", fail_count);
    end
    step(1, 0, 0);
    n_cmp++;
    if (fail_count !== 3'd2) begin
      n_err++; $display("FAIL fail2: got %0d want 2", fail_count);
    end
    step(1, 0, 0);
    n_cmp++;
    if (state !== 2'b10 || fail_count !== 3'd0) begin
      n_err++; $display("FAIL lockout_entry: got s=%0d f=%0d want s=2 f=0", state, fail_count);
    end
    for (int i = 0; i < L; i++) begin
      n_cmp++;
      if (lockout !== 1'b1 || unlock !== 1'b0 || intruder_alert !== (i == 0)) begin
        n_err++;
        $display("FAIL lockout_window[%0d]: got lo=%b u=%b a=%b want lo=1 u=0 a=%b",
                 i, lockout, unlock, intruder_alert, (i == 0));
      end
      step(i == 4 || i == 9, 1, 0);
    end
    n_cmp++;
    if (lockout !== 1'b0 || state !== 2'b00 || intruder_alert !== 1'b0) begin
      n_err++;
      $display("FAIL lockout_expire: got lo=%b s=%0d a=%b want 0 0 0", lockout, state, intruder_alert);
    end
  endtask

  task automatic test_match_clears_fails();
    int cnt;
    do_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    n_cmp++;
    if (fail_count !== 3'd2) begin
      n_err++; $display("FAIL pre_match_fails: got %0d want 2", fail_count);
    end
    step(1, 1, 0);
    n_cmp++;
    if (fail_count !== 3'd0 || state !== 2'b01) begin
      n_err++; $display("FAIL match_clears: got f=%0d s=%0d want f=0 s=1", fail_count, state);
    end
    cnt = 0;
    for (int i = 0; i < 40 && unlock === 1'b1; i++) begin
      cnt++;
      step(0, 0, 0);
    end
    n_cmp++;
    if (cnt != U) begin
      n_err++; $display("FAIL match_window_len: got %0d want %0d", cnt, U);
    end
    step(1, 0, 0);
    n_cmp++;
    if (fail_count !== 3'd1 || lockout !== 1'b0 || state !== 2'b00) begin
      n_err++;
      $display("FAIL single_mismatch: got f=%0d lo=%b s=%0d want f=1 lo=0 s=0", fail_count, lockout, state);
    end
  endtask

  task automatic test_back_to_back_extension();
    int cnt;
    do_reset();
    step(1, 1, 0);
    cnt = 0;
    for (int i = 0; i < 40 && unlock === 1'b1; i++) begin
      cnt++;
      step(i == 4 || i == 7, i == 4, 0);
      n_cmp++;
      if (fail_count !== 3'd0) begin
        n_err++; $display("FAIL ext_fail_count[%0d]: got %0d want 0", i, fail_count);
      end
    end
    n_cmp++;
    if (cnt != 5 + U) begin
      n_err++; $display("FAIL ext_window_len: got %0d want %0d", cnt, 5 + U);
    end
    // Reload on the very last unlocked cycle keeps the door open.
    do_reset();
    step(1, 1, 0);
    for (int i = 0; i < U - 1; i++) step(0, 0, 0);
    step(1, 1, 0);
    n_cmp++;
    if (state !== 2'b01 || unlock !== 1'b1) begin
      n_err++; $display("FAIL ext_last_cycle: got s=%0d u=%b want s=1 u=1", state, unlock);
    end
  endtask

  task automatic test_emergency();
    do_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(0, 0, 1);
    n_cmp++;
    if (state !== 2'b11 || unlock !== 1'b1 || lockout !== 1'b0) begin
      n_err++;
      $display("FAIL emerg_entry: got s=%0d u=%b lo=%b want s=3 u=1 lo=0", state, unlock, lockout);
    end
    step(1, 0, 1);
    step(1, 0, 1);
    step(1, 1, 1);
    n_cmp++;
    if (state !== 2'b11 || fail_count !== 3'd0 || intruder_alert !== 1'b0) begin
      n_err++;
      $display("FAIL emerg_hold: got s=%0d f=%0d a=%b want s=3 f=0 a=0", state, fail_count, intruder_alert);
    end
    step(0, 0, 0);
    n_cmp++;
    if (state !== 2'b00 || fail_count !== 3'd0 || unlock !== 1'b0) begin
      n_err++;
      $display("FAIL emerg_exit: got s=%0d f=%0d u=%b want s=0 f=0 u=0", state, fail_count, unlock);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (unlock !== 1'b0 || lockout !== 1'b0 || state !== 2'b00 || fail_count !== 3'd0) begin
      n_err++;
      $display("FAIL async_reset: got u=%b lo=%b s=%0d f=%0d want 0 0 0 0", unlock, lockout, state, fail_count);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1, 0, 0);
    n_cmp++;
    if (fail_count !== 3'd1 || state !== 2'b00) begin
      n_err++; $display("FAIL post_reset_mismatch: got f=%0d s=%0d want f=1 s=0", fail_count, state);
    end
  endtask

  task automatic test_random();
    int emerg_left = 0;
    bit v, m, e;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (emerg_left == 0 && $urandom_range(0, 99) < 2) emerg_left = $urandom_range(1, 5);
      e = (emerg_left > 0);
      if (emerg_left > 0) emerg_left--;
      v = ($urandom_range(0, 99) < 40);
      m = ($urandom_range(0, 99) < 30);
      step(v, m, e);
      n_cmp++;
      if (state !== 2'(m_mode) || unlock !== (m_mode == 1 || m_mode == 3) ||
          lockout !== (m_mode == 2) || intruder_alert !== m_alert ||
          fail_count !== 3'(m_fails)) begin
        n_err++;
        $display("FAIL random[%0d]: got s=%0d u=%b lo=%b a=%b f=%0d want s=%0d u=%b lo=%b a=%b f=%0d",
                 i, state, unlock, lockout, intruder_alert, fail_count,
                 m_mode, (m_mode == 1 || m_mode == 3), (m_mode == 2), m_alert, m_fails);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    code_valid = 1'b0;
    code_match = 1'b0;
    emergency  = 1'b0;
    model_reset();
    test_reset();
    test_unlock();
    test_lockout();
    test_match_clears_fails();
    test_back_to_back_extension();
    test_emergency();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
